uart_tx_arbiter: RTL and testbench

//   Shares one byte-wide UART transmitter between NUM_REQ on-chip requesters.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NUM_REQ requesters.
// Optional per-byte timeout with nack when UART_ARB_TIMEOUT_EN is defined.

module uart_tx_arb_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];
endmodule

module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TMO_W          = 17
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         nack,
   output logic                       arb_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       uart_tx_start,
   output logic [7:0]                 uart_tx_data,
   input  logic                       uart_tx_busy,
   input  logic                       uart_tx_clear_req
);
   localparam int IW = $clog2(NUM_REQ);

`ifdef UART_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ABORT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
`endif

   state_t        state, state_nxt;
   logic          busy_s, clr_s, clr_s_d, clr_rise;
   logic [IW-1:0] rr_ptr, pick, next_ptr;
   logic          found, grant;
   logic          tmo;

   uart_tx_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_busy (
      .clk(clk), .rst_n(rst_n), .d(uart_tx_busy), .q(busy_s));
   uart_tx_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .clk(clk), .rst_n(rst_n), .d(uart_tx_clear_req), .q(clr_s));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clr_s_d <= 1'b0;
      else        clr_s_d <= clr_s;
   end
   assign clr_rise = clr_s & ~clr_s_d;

   // First set request at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   assign grant    = (state == S_IDLE) && found && !busy_s;
   assign next_ptr = (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    tmo_cnt <= '0;
      else if (grant)                                tmo_cnt <= '0;
      else if (state == S_START || state == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign tmo = (state == S_START || state == S_WAIT) &&
                (tmo_cnt == TMO_W'(TIMEOUT_CYCLES-1));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Completion has priority over a timeout landing in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant) state_nxt = S_START;
         S_START: begin
            if (busy_s)        state_nxt = S_WAIT;
            else if (clr_rise) state_nxt = S_DONE;
`ifdef UART_ARB_TIMEOUT_EN
            else if (tmo)      state_nxt = S_ABORT;
`endif
         end
         S_WAIT: begin
            if (clr_rise || !busy_s) state_nxt = S_DONE;
`ifdef UART_ARB_TIMEOUT_EN
            else if (tmo)            state_nxt = S_ABORT;
`endif
         end
         S_DONE:  state_nxt = S_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
         S_ABORT: state_nxt = S_IDLE;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Granted id and byte stay frozen from grant until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_id     <= '0;
         uart_tx_data <= '0;
         rr_ptr       <= '0;
      end else begin
         if (grant) begin
            grant_id     <= pick;
            uart_tx_data <= req_data[8*pick +: 8];
         end
`ifdef UART_ARB_TIMEOUT_EN
         if (state == S_DONE || state == S_ABORT) rr_ptr <= next_ptr;
`else
         if (state == S_DONE) rr_ptr <= next_ptr;
`endif
      end
   end

   always_comb begin
      ack  = '0;
      nack = '0;
      if (state == S_DONE) ack[grant_id] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
      if (state == S_ABORT) nack[grant_id] = 1'b1;
`endif
      uart_tx_start = (state == S_START) && !busy_s;
      arb_busy      = (state != S_IDLE);
   end

   logic unused_tmo;
   assign unused_tmo = tmo;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of grants plus hand-written corner sequences.

module tb_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack, nack;
   logic        arb_busy;
   logic [1:0]  grant_id;
   logic        uart_tx_start;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_busy = 1'b0;
   logic        uart_tx_clear_req = 1'b0;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64), .TMO_W(17)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack), .nack(nack),
      .arb_busy(arb_busy), .grant_id(grant_id), .uart_tx_start(uart_tx_start),
      .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
      .uart_tx_clear_req(uart_tx_clear_req));

   always #5 clk = ~clk;

   typedef struct {
      bit          do_rst;
      logic [3:0]  req;
      logic [31:0] data;
      int          id;
      logic [7:0]  byte_exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_start"}, {31'd0, uart_tx_start}, 32'd0);
      chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
      chk({tag, "_nack"}, {28'd0, nack}, 32'd0);
      chk({tag, "_busy"}, {31'd0, arb_busy}, 32'd0);
      chk({tag, "_gid"}, {30'd0, grant_id}, 32'd0);
      chk({tag, "_data"}, {24'd0, uart_tx_data}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_start();
      for (int i = 0; i < 100 && !uart_tx_start; i++) @(negedge clk);
      chk("start_seen", {31'd0, uart_tx_start}, 32'd1);
   endtask

   task automatic wait_done(input int id, input string tag);
      for (int i = 0; i < 100 && ack == 4'd0 && nack == 4'd0; i++) begin
         @(negedge clk);
         if (i == 2) uart_tx_clear_req = 1'b0;
      end
      uart_tx_clear_req = 1'b0;
      chk({tag, "_ack"}, {28'd0, ack}, 32'd1 << id);
      chk({tag, "_nack"}, {28'd0, nack}, 32'd0);
      req = '0;
      @(negedge clk);
      chk({tag, "_ack_pulse"}, {28'd0, ack}, 32'd0);
      chk({tag, "_idle"}, {31'd0, arb_busy}, 32'd0);
   endtask

   // Transmitter model: raise busy once start is seen, then end the byte with clear.
   task automatic serve(input int id, input logic [7:0] b);
      wait_start();
      chk("grant_id", {30'd0, grant_id}, id);
      chk("tx_data", {24'd0, uart_tx_data}, {24'd0, b});
      chk("arb_busy", {31'd0, arb_busy}, 32'd1);
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 20 && uart_tx_start; i++) @(negedge clk);
      chk("start_drop", {31'd0, uart_tx_start}, 32'd0);
      repeat (3) @(negedge clk);
      uart_tx_busy = 1'b0;
      uart_tx_clear_req = 1'b1;
      wait_done(id, "serve");
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'b0001, 32'h000000A5, 0, 8'hA5};
      vecs[1] = '{1'b1, 4'b1111, 32'h13121110, 0, 8'h10};
      vecs[2] = '{1'b0, 4'b1111, 32'h13121110, 1, 8'h11};
      vecs[3] = '{1'b0, 4'b1111, 32'h13121110, 2, 8'h12};
      vecs[4] = '{1'b0, 4'b1111, 32'h13121110, 3, 8'h13};
      vecs[5] = '{1'b0, 4'b1111, 32'h13121110, 0, 8'h10};
      vecs[6] = '{1'b0, 4'b0101, 32'h13121110, 2, 8'h12};
      vecs[7] = '{1'b0, 4'b1001, 32'h13121110, 3, 8'h13};
      vecs[8] = '{1'b0, 4'b1001, 32'h13121110, 0, 8'h10};
      vecs[9] = '{1'b0, 4'b0101, 32'h13121110, 2, 8'h12};

      #1;
      check_idle_outputs("por");

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].do_rst) do_reset();
         req      = vecs[v].req;
         req_data = vecs[v].data;
         serve(vecs[v].id, vecs[v].byte_exp);
      end

      // Busy gate: transmitter busy from reset, no start until it goes idle.
      uart_tx_busy = 1'b1;
      do_reset();
      repeat (3) @(negedge clk);
      req      = 4'b0010;
      req_data = 32'h00005A00;
      begin
         bit saw = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (uart_tx_start || arb_busy) saw = 1'b1;
         end
         chk("busy_gate", {31'd0, saw}, 32'd0);
      end
      uart_tx_busy = 1'b0;
      serve(1, 8'h5A);

      // Reset in WAIT_DONE: outputs clear at once, no ack, then a fresh grant.
      do_reset();
      req      = 4'b0100;
      req_data = 32'h00C30000;
      wait_start();
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 20 && uart_tx_start; i++) @(negedge clk);
      @(negedge clk);
      chk("wait_busy", {31'd0, arb_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      uart_tx_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      serve(2, 8'hC3);

      // Completion seen in START, busy pulse missed; req and data change after grant.
      do_reset();
      req      = 4'b1000;
      req_data = 32'h7E000000;
      wait_start();
      req      = 4'b0000;
      req_data = 32'h11111111;
      uart_tx_clear_req = 1'b1;
      @(negedge clk);
      chk("frozen_data", {24'd0, uart_tx_data}, 32'h7E);
      chk("frozen_id", {30'd0, grant_id}, 32'd3);
      wait_done(3, "clr_in_start");

`ifdef UART_ARB_TIMEOUT_EN
      // Transmitter never reacts: nack after 64 cycles of START, then next requester.
      do_reset();
      req      = 4'b0001;
      req_data = 32'h0000BB11;
      wait_start();
      begin
         int n = 0;
         while (n < 200 && nack == 4'd0 && ack == 4'd0) begin
            @(negedge clk);
            n++;
         end
         chk("tmo_cycles", n, 32'd64);
         chk("tmo_nack", {28'd0, nack}, 32'd1);
         chk("tmo_ack", {28'd0, ack}, 32'd0);
      end
      req = 4'b0011;
      serve(1, 8'hBB);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end
endmodule
